// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs opcode, register fields and a full
// immediate into an instruction word, with range checks and an output FIFO.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [32:0]      mem_q [DEPTH];
  logic [32:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic        push, pop;
  logic        i_ok, b_ok, j_ok, u_ok, sh_ok, enc_ok;
  logic [31:0] enc_instr;
  logic [32:0] entry;

  // Immediate range checks: the bits above the encodable field must be pure sign.
  always_comb begin
    i_ok  = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    b_ok  = !in_imm[0] && ((in_imm[31:12] == '0) || (in_imm[31:12] == '1));
    j_ok  = !in_imm[0] && ((in_imm[31:20] == '0) || (in_imm[31:20] == '1));
    u_ok  = (in_imm[11:0] == '0);
    sh_ok = (in_imm[31:5] == '0);
  end

  always_comb begin
    enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    enc_ok    = 1'b0;
    case (in_opcode)
      OP_LOAD: enc_ok = i_ok;
      OP_IMM: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_ok    = sh_ok;
        end else begin
          enc_ok = i_ok;
        end
      end
      OP_JALR: begin
        enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
        enc_ok    = i_ok;
      end
      OP_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_ok    = i_ok;
      end
      OP_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_ok    = b_ok;
      end
      OP_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_ok    = j_ok;
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_ok    = u_ok;
      end
      default: enc_ok = 1'b0;
    endcase
    entry = enc_ok ? {1'b0, enc_instr} : {1'b1, NOP};
  end

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      enc_count_d     = enc_count_q + CNT_W'(1);
      if (entry[32] && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because the head entry drives out_instr/out_err
      // directly, and those must read zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_instr = mem_q[rd_ptr_q][31:0];
  assign out_err   = mem_q[rd_ptr_q][32];
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, backpressure, reset,
// random legal vectors checked through an immediate-extend model, err saturation.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    bit          by_decode;
    logic [31:0] imm;
    logic [6:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_enc = '0;
  int          exp_err = 0;

  function automatic exp_t mk(input logic [31:0] instr, input logic err);
    exp_t e;
    e.instr = instr; e.err = err; e.by_decode = 1'b0; e.imm = '0; e.op = '0;
    return e;
  endfunction

  function automatic exp_t mk_dec(input logic [31:0] imm, input logic [6:0] op);
    exp_t e;
    e.instr = '0; e.err = 1'b0; e.by_decode = 1'b1; e.imm = imm; e.op = op;
    return e;
  endfunction

  // Reference immediate-extend unit: recovers the immediate from an instruction word.
  function automatic logic [31:0] ext_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0000011, 7'b1100111: return {{20{i[31]}}, i[31:20]};
      7'b0010011: return (i[13:12] == 2'b01) ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
      7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      7'b0110111, 7'b0010111: return {i[31:12], 12'b0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One clock from a falling edge to the next; scoreboards whatever handshakes occur.
  task automatic cycle(output bit acc);
    bit          pop;
    exp_t        e;
    logic [31:0] got;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got instr=%h err=%b, required no output", out_instr, out_err);
      end else begin
        e = sb.pop_front();
        if (e.by_decode) begin
          got = ext_imm(out_instr);
          if (out_err !== 1'b0 || out_instr[6:0] !== e.op || got !== e.imm)
            $display("FAIL decode: instr=%h err=%b op=%b imm=%h, required err=0 op=%b imm=%h",
                     out_instr, out_err, out_instr[6:0], got, e.op, e.imm);
          else n_pass++;
        end else if ({out_err, out_instr} !== {e.err, e.instr}) begin
          $display("FAIL output: got instr=%h err=%b, required instr=%h err=%b",
                   out_instr, out_err, e.instr, e.err);
        end else n_pass++;
      end
    end
    if (acc) begin
      sb.push_back(cur);
      exp_enc++;
      if (cur.err && exp_err < 255) exp_err++;
    end
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (enc_count !== exp_enc || err_count !== 8'(exp_err))
      $display("FAIL counters: got enc=%0d err=%0d, required enc=%0d err=%0d",
               enc_count, err_count, exp_enc, exp_err);
    else n_pass++;
  endtask

  task automatic send(input exp_t e);
    bit acc = 1'b0;
    cur = e;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) cycle(acc);
    n_total++;
    if (!acc) $display("FAIL send_timeout: got accepted=0, required accepted=1");
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() > 0; k++) cycle(acc);
    n_total++;
    if (sb.size() != 0) $display("FAIL drain_timeout: got pending=%0d, required pending=0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 ||
        enc_count !== 16'h0 || err_count !== 8'h0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got valid=%b instr=%h err=%b enc=%0d errc=%0d ready=%b, required 0/0/0/0/0/1",
               out_valid, out_instr, out_err, enc_count, err_count, in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF);
    send(mk(32'hFFF0_0093, 1'b0));
    n_total++;
    if (out_valid !== 1'b1 || enc_count !== 16'd1)
      $display("FAIL first_latency: got valid=%b enc=%0d, required valid=1 enc=1", out_valid, enc_count);
    else n_pass++;
    drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
    send(mk(32'h0051_2423, 1'b0));
    drive(7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
    send(mk(32'h1234_51B7, 1'b0));
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800);
    send(mk(32'h0010_00EF, 1'b0));
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
    send(mk(32'h0000_0013, 1'b1));
    drain();
    n_total++;
    if (err_count !== 8'd1) $display("FAIL odd_branch_errcount: got %0d, required 1", err_count);
    else n_pass++;
    // Boundary immediates and special forms.
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_07FF);
    send(mk(32'h7FF0_0093, 1'b0));
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800);
    send(mk(32'h0000_0013, 1'b1));
    drive(7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001);
    send(mk(32'h0000_0013, 1'b1));
    drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd31);
    send(mk(32'h01F0_9093, 1'b0));
    drive(7'b0010011, 5'd3, 5'd2, 5'd0, 3'b101, 7'h20, 32'd5);
    send(mk(32'h4051_5193, 1'b0));
    drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32);
    send(mk(32'h0000_0013, 1'b1));
    drive(7'b1100111, 5'd1, 5'd5, 5'd0, 3'b111, 7'd0, 32'd4);
    send(mk(32'h0042_80E7, 1'b0));
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC);
    send(mk(32'hFE20_8EE3, 1'b0));
    drive(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0);
    send(mk(32'h0000_0013, 1'b1));
    drain();
  endtask

  task automatic test_backpressure();
    bit          acc;
    logic [31:0] head;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int r = 1; r <= 2; r++) begin
      drive(7'b0010011, 5'(r), 5'd0, 5'd0, 3'b000, 7'd0, 32'(r));
      cur = mk({12'(r), 5'd0, 3'b000, 5'(r), 7'b0010011}, 1'b0);
      cycle(acc);
      n_total++;
      if (!acc) $display("FAIL bp_accept%0d: got accepted=0, required 1", r);
      else n_pass++;
    end
    drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);
    cur = mk(32'h0030_0193, 1'b0);
    head = out_instr;
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      n_total++;
      if (acc || in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== head)
        $display("FAIL bp_stall: got acc=%b ready=%b valid=%b instr=%h, required 0/0/1/%h",
                 acc, in_ready, out_valid, out_instr, head);
      else n_pass++;
    end
    out_ready = 1'b1;
    cycle(acc);
    n_total++;
    if (acc) $display("FAIL bp_no_passthrough: got accepted=1 while full, required 0");
    else n_pass++;
    cycle(acc);
    n_total++;
    if (!acc) $display("FAIL bp_third_accept: got accepted=0, required 1");
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_midop();
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(7'b0110111, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'hABCD_E000);
    cur = mk(32'hABCD_E3B7, 1'b0);
    cycle(acc);
    cycle(acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 8'd0)
      $display("FAIL async_reset: got valid=%b enc=%0d err=%0d, required 0/0/0",
               out_valid, enc_count, err_count);
    else n_pass++;
    sb.delete();
    exp_enc = '0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          acc;
    logic [31:0] r, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    int          t;
    for (int n = 0; n < 200; n++) begin
      r  = $urandom;
      t  = $urandom_range(0, 7);
      f3 = 3'($urandom_range(0, 7));
      case (t)
        0: begin op = 7'b0000011; imm = {{20{r[11]}}, r[11:0]}; end
        1: begin op = 7'b0010011; imm = {{20{r[11]}}, r[11:0]}; if (f3[1:0] == 2'b01) f3[0] = 1'b0; end
        2: begin op = 7'b0010011; imm = {27'b0, r[4:0]}; f3 = r[31] ? 3'b101 : 3'b001; end
        3: begin op = 7'b1100111; imm = {{20{r[11]}}, r[11:0]}; end
        4: begin op = 7'b0100011; imm = {{20{r[11]}}, r[11:0]}; end
        5: begin op = 7'b1100011; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
        6: begin op = 7'b1101111; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
        default: begin op = r[0] ? 7'b0110111 : 7'b0010111; imm = {r[31:12], 12'b0}; end
      endcase
      drive(op, 5'($urandom), 5'($urandom), 5'($urandom), f3, {1'b0, r[31], 5'b0}, imm);
      cur = mk_dec(imm, op);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cycle(acc);
      end
      n_total++;
      if (!acc) $display("FAIL random_timeout: got accepted=0, required 1");
      else n_pass++;
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) cycle(acc);
    end
    drain();
  endtask

  task automatic test_err_saturation();
    for (int n = 0; n < 300; n++) begin
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd1);
      send(mk(32'h0000_0013, 1'b1));
    end
    drain();
    n_total++;
    if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d, required 255", err_count);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    cur = mk(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_err_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder. It packs opcode, register fields and a full 32-bit immediate value back into a 32-bit instruction word, which is the inverse of the core's immediate-extend unit. It is used by the boot-ROM/test-program loader path and by the scoreboard self-check to regenerate instruction words. Input and output use valid/ready handshakes, with a small output FIFO between them. Per-instruction range checks flag immediates that cannot be encoded.

Parameters:
DEPTH, 2, output FIFO depth in entries; power of 2, at least 2.
CNT_W, 16, width of the encoded-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
in_opcode  in  7  instr[6:0] opcode
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7; used only for OP-IMM shifts
in_imm  in  32  full immediate value, as the extend unit would output it
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  encoded instruction word
out_err  out  1  head entry failed the encode check
enc_count  out  CNT_W  accepted requests, wraps
err_count  out  8  failed requests, saturates at 255

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, in_ready=1.
- Reset asserted mid-operation: all FIFO entries are discarded immediately and out_valid drops without waiting for a clock edge.
- Input handshake: a request is accepted on a rising edge with in_valid && in_ready.
- in_ready = (occupancy < DEPTH). There is no same-cycle pass-through: when the FIFO is full, in_ready=0 even if out_ready=1.
- Output handshake: an entry pops on a rising edge with out_valid && out_ready.
- out_instr and out_err are registered FIFO-head values and hold stable while out_valid && !out_ready.
- Latency: a request accepted at edge N is visible at the output after edge N when the FIFO was empty.
- Ordering is strictly FIFO. Simultaneous push and pop keeps occupancy unchanged. Read/write pointers wrap modulo DEPTH.
- Packing by opcode (encoding is combinational from the inputs and is written into the FIFO on accept):
  - 0000011 LOAD: {imm[11:0], rs1, funct3, rd, op}.
  - 0010011 OP-IMM, funct3=001 or 101: {funct7, imm[4:0], rs1, funct3, rd, op}.
  - 0010011 OP-IMM, other funct3: I-type as for LOAD.
  - 1100111 JALR: I-type with funct3 forced to 000.
  - 0100011 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - 1100011 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - 1101111 JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - 0110111 LUI and 0010111 AUIPC: {imm[31:12], rd, op}.
- Error checks (err=1 on any failure):
  - I/S types: in_imm[31:11] all equal.
  - B type: in_imm[0]=0 and in_imm[31:12] all equal.
  - J type: in_imm[0]=0 and in_imm[31:20] all equal.
  - U type: in_imm[11:0]=0.
  - Shifts: in_imm[31:5]=0.
  - Any other opcode is an error.
- On error, the entry stores out_instr=32'h0000_0013 (NOP) with out_err=1.
- Counters:
  - enc_count increments on every accept and wraps at 2^CNT_W.
  - err_count increments on every accepted errored request and holds at 255.
  - Both update on the accept edge.

Test Plan:
- addi: op=0010011, rd=1, rs1=0, f3=000, imm=32'hFFFF_FFFF -> out_instr=32'hFFF0_0093, err=0, enc_count=1.
- sw x5,8(x2): op=0100011, rs1=2, rs2=5, f3=010, imm=8 -> 32'h0051_2423. lui x3: op=0110111, rd=3, imm=32'h1234_5000 -> 32'h1234_51B7.
- jal x1: op=1101111, rd=1, imm=32'h800 -> 32'h0010_00EF. Branch with imm=3 (odd) -> out_instr=32'h0000_0013, out_err=1, err_count=1.
- Backpressure: hold out_ready=0 and present 3 back-to-back requests.
  - Expect in_ready=0 after 2 accepts and the third request held.
  - Raise out_ready: 3 outputs in order, output stable while stalled.
  - Full FIFO with out_ready=1: no same-cycle accept.
- Reset: with 2 entries queued, drive rst_n low between edges -> out_valid=0 and counters=0 immediately, in_ready=1 after release.
- Random legal vectors: feed out_instr into the core's immediate-extend unit -> result equals in_imm. Also check err_count saturation at 255 after 300 bad requests.
